// File: rtl/dm_wbuf_if.sv
// -----------------------------------------------------------------------------
// dm_wbuf_if
// Bundle of the CPU-side (MEM stage) and memory-side signals of the posted-write
// buffer.
//   master : pipeline + backing memory (drives cpu_*, mem_rdata, mem_wack)
//   slave  : the write buffer (drives cpu_dout, stall, mem_raddr, mem_w*,
//            empty, count)
// Signals:
//   cpu_addr/cpu_din/cpu_we/cpu_re : MEM stage request (byte address, word data)
//   cpu_dout                       : load data (forwarded or from memory)
//   stall                          : store cannot be accepted this cycle
//   mem_raddr/mem_rdata            : combinational backing-memory read
//   mem_wreq/mem_waddr/mem_wdata   : head-entry write request
//   mem_wack                       : memory accepted the head write
//   empty/count                    : occupancy
// Parameter PTRW must match the dm_wbuf instance it connects to.
// -----------------------------------------------------------------------------
interface dm_wbuf_if #(
  parameter int PTRW = 2
);
  logic [31:0]   cpu_addr;
  logic [31:0]   cpu_din;
  logic          cpu_we;
  logic          cpu_re;
  logic [31:0]   cpu_dout;
  logic          stall;
  logic [31:0]   mem_raddr;
  logic [31:0]   mem_rdata;
  logic          mem_wreq;
  logic [31:0]   mem_waddr;
  logic [31:0]   mem_wdata;
  logic          mem_wack;
  logic          empty;
  logic [PTRW:0] count;

  modport master (
    output cpu_addr, cpu_din, cpu_we, cpu_re, mem_rdata, mem_wack,
    input  cpu_dout, stall, mem_raddr, mem_wreq, mem_waddr, mem_wdata,
           empty, count
  );

  modport slave (
    input  cpu_addr, cpu_din, cpu_we, cpu_re, mem_rdata, mem_wack,
    output cpu_dout, stall, mem_raddr, mem_wreq, mem_waddr, mem_wdata,
           empty, count
  );
endinterface

// File: rtl/dm_wbuf.sv
// -----------------------------------------------------------------------------
// dm_wbuf
// Posted-write buffer between the MEM stage and data memory. Stores are queued
// in a DEPTH-entry circular FIFO of {tag, data} and drained over a req/ack
// write port; loads read memory combinationally but return the data of the
// youngest queued store to the same word when one exists.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset (drops all queued stores)
//   bus  : dm_wbuf_if.slave (CPU request/load data, memory read/write port)
// Parameters: DEPTH (power of two, >= 2), PTRW = log2(DEPTH).
// Build option: define WBUF_COALESCE_EN to merge a store into a matching
// non-head queued entry instead of allocating a new one.
// -----------------------------------------------------------------------------
module dm_wbuf #(
  parameter int DEPTH = 4,
  parameter int PTRW  = 2
) (
  input  logic       clk,
  input  logic       rst,
  dm_wbuf_if.slave   bus
);

  localparam logic [PTRW:0] FULL_COUNT = (PTRW+1)'(DEPTH);

  logic [29:0]     r_tag  [DEPTH];
  logic [31:0]     r_data [DEPTH];
  logic [PTRW-1:0] r_wr_ptr;
  logic [PTRW-1:0] r_rd_ptr;
  logic [PTRW:0]   r_count;

  logic [29:0]     w_cpu_tag;
  logic            w_full;
  logic            w_push;
  logic            w_pop;
  logic            w_fwd_hit;
  logic [31:0]     w_fwd_data;

  assign w_cpu_tag = bus.cpu_addr[31:2];
  assign w_full    = (r_count == FULL_COUNT);
  assign w_pop     = bus.mem_wreq & bus.mem_wack;

  // Forwarding: walk entries oldest to youngest so the last match wins.
  // Validity is age-based (offset from rd_ptr below count), which keeps full
  // and empty distinct even though the pointers are equal in both cases.
  // NOTE: every always_comb output is defaulted first so no latch is inferred.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (((PTRW+1)'(k) < r_count) &&
          (r_tag[r_rd_ptr + PTRW'(k)] == w_cpu_tag)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_data[r_rd_ptr + PTRW'(k)];
      end
    end
  end

`ifdef WBUF_COALESCE_EN
  logic            w_coal_hit;
  logic [PTRW-1:0] w_coal_idx;

  // Coalesce candidates skip the head (k=0): it may be mid-handshake, so its
  // data must stay stable until acked.
  always_comb begin
    w_coal_hit = 1'b0;
    w_coal_idx = '0;
    for (int k = 1; k < DEPTH; k++) begin
      if (((PTRW+1)'(k) < r_count) &&
          (r_tag[r_rd_ptr + PTRW'(k)] == w_cpu_tag)) begin
        w_coal_hit = bus.cpu_we;
        w_coal_idx = r_rd_ptr + PTRW'(k);
      end
    end
  end

  // A coalescing store needs no free slot, so it never stalls.
  assign bus.stall = bus.cpu_we & w_full & ~w_coal_hit;
  assign w_push    = bus.cpu_we & ~bus.stall & ~w_coal_hit;
`else
  assign bus.stall = bus.cpu_we & w_full;
  assign w_push    = bus.cpu_we & ~bus.stall;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: entry storage is deliberately not reset; validity comes from the
  // pointers and count, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tag[r_wr_ptr]  <= w_cpu_tag;
      r_data[r_wr_ptr] <= bus.cpu_din;
    end
`ifdef WBUF_COALESCE_EN
    else if (w_coal_hit) begin
      r_data[w_coal_idx] <= bus.cpu_din;
    end
`endif
  end

  assign bus.empty     = (r_count == '0);
  assign bus.count     = r_count;
  assign bus.mem_wreq  = ~bus.empty;
  assign bus.mem_waddr = {r_tag[r_rd_ptr], 2'b00};
  assign bus.mem_wdata = r_data[r_rd_ptr];
  assign bus.mem_raddr = bus.cpu_addr;
  assign bus.cpu_dout  = (bus.cpu_re && w_fwd_hit) ? w_fwd_data : bus.mem_rdata;

endmodule

// File: tb/tb_dm_wbuf.sv
// -----------------------------------------------------------------------------
// tb_dm_wbuf
// Directed bench for dm_wbuf (DEPTH=4). Inputs change 1 time unit after the
// rising edge; outputs are checked 1 unit later, well away from the next edge.
// The coalescing sequence runs only when WBUF_COALESCE_EN is defined.
// -----------------------------------------------------------------------------
module tb_dm_wbuf;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  dm_wbuf_if #(.PTRW(2)) bus ();

  dm_wbuf #(.DEPTH(4), .PTRW(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [31:0] addr, input logic [31:0] data);
    bus.cpu_we   = 1'b1;
    bus.cpu_re   = 1'b0;
    bus.cpu_addr = addr;
    bus.cpu_din  = data;
  endtask

  task automatic load(input logic [31:0] addr);
    bus.cpu_we   = 1'b0;
    bus.cpu_re   = 1'b1;
    bus.cpu_addr = addr;
  endtask

  task automatic idle();
    bus.cpu_we = 1'b0;
    bus.cpu_re = 1'b0;
  endtask

  initial begin
    bus.cpu_addr  = '0;
    bus.cpu_din   = '0;
    bus.cpu_we    = 1'b0;
    bus.cpu_re    = 1'b0;
    bus.mem_rdata = 32'h0000_DEAD;
    bus.mem_wack  = 1'b0;

    // ---- reset state
    tick();
    #1;
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_wreq",  32'(bus.mem_wreq), 32'd0);
    check("rst_stall", 32'(bus.stall), 32'd0);
    rst = 1'b0;
    tick();

    // ---- single store, visible on the write port next cycle
    store(32'h10, 32'hAAAA_0001);
    #1 check("t1_stall", 32'(bus.stall), 32'd0);
    tick();
    idle();
    #1;
    check("t1_count", 32'(bus.count), 32'd1);
    check("t1_wreq",  32'(bus.mem_wreq), 32'd1);
    check("t1_waddr", bus.mem_waddr, 32'h10);
    check("t1_wdata", bus.mem_wdata, 32'hAAAA_0001);
    bus.mem_wack = 1'b1;
    tick();
    bus.mem_wack = 1'b0;
    #1 check("t1_drained", 32'(bus.empty), 32'd1);

    // ---- fill to DEPTH, fifth store stalls until one entry pops
    for (int i = 0; i < 4; i++) begin
      store(32'h20 + 32'(4*i), 32'hB0 + 32'(i));
      #1 check("t2_nostall", 32'(bus.stall), 32'd0);
      tick();
    end
    store(32'h30, 32'hB4);
    #1;
    check("t2_full_count", 32'(bus.count), 32'd4);
    check("t2_stall", 32'(bus.stall), 32'd1);
    tick();
    check("t2_held_count", 32'(bus.count), 32'd4);
    bus.mem_wack = 1'b1;
    #1 check("t2_stall_ack", 32'(bus.stall), 32'd1);
    tick();
    bus.mem_wack = 1'b0;
    #1;
    check("t2_unstall", 32'(bus.stall), 32'd0);
    check("t2_count3", 32'(bus.count), 32'd3);
    check("t2_head", bus.mem_waddr, 32'h24);
    tick();
    idle();
    #1 check("t2_count4", 32'(bus.count), 32'd4);
    bus.mem_wack = 1'b1;
    for (int i = 1; i < 5; i++) begin
      check("t2_drain_addr", bus.mem_waddr, 32'h20 + 32'(4*i));
      check("t2_drain_data", bus.mem_wdata, 32'hB0 + 32'(i));
      tick();
    end
    bus.mem_wack = 1'b0;
    #1 check("t2_empty", 32'(bus.empty), 32'd1);

    // ---- forwarding of the youngest matching store (pointers have wrapped)
    store(32'h40, 32'h1);
    tick();
    store(32'h40, 32'h2);
    tick();
    load(32'h40);
    #1;
    check("t3_count", 32'(bus.count), 32'd2);
    check("t3_fwd", bus.cpu_dout, 32'h2);
    check("t3_raddr", bus.mem_raddr, 32'h40);
    load(32'h42);
    #1 check("t3_fwd_byteoff", bus.cpu_dout, 32'h2);
    load(32'h44);
    #1 check("t3_miss", bus.cpu_dout, 32'h0000_DEAD);
    bus.mem_wack = 1'b1;
    tick();
    load(32'h40);
    #1 check("t3_one_left", bus.cpu_dout, 32'h2);
    tick();
    bus.mem_wack = 1'b0;
    #1;
    check("t3_after_drain", bus.cpu_dout, 32'h0000_DEAD);
    check("t3_empty", 32'(bus.empty), 32'd1);
    idle();

    // ---- back-to-back drain with mem_wack held high
    bus.mem_wack = 1'b1;
    store(32'h50, 32'h5);
    tick();
    store(32'h54, 32'h6);
    #1;
    check("t4_a0", bus.mem_waddr, 32'h50);
    check("t4_d0", bus.mem_wdata, 32'h5);
    tick();
    store(32'h58, 32'h7);
    #1;
    check("t4_a1", bus.mem_waddr, 32'h54);
    check("t4_d1", bus.mem_wdata, 32'h6);
    check("t4_count", 32'(bus.count), 32'd1);
    tick();
    idle();
    #1;
    check("t4_a2", bus.mem_waddr, 32'h58);
    check("t4_d2", bus.mem_wdata, 32'h7);
    tick();
    #1 check("t4_empty", 32'(bus.empty), 32'd1);
    bus.mem_wack = 1'b0;

    // ---- reset in the middle of a drain
    for (int i = 0; i < 3; i++) begin
      store(32'h70 + 32'(4*i), 32'hC0 + 32'(i));
      tick();
    end
    idle();
    bus.mem_wack = 1'b1;
    tick();
    check("t5_pre_count", 32'(bus.count), 32'd2);
    rst = 1'b1;
    #1;
    check("t5_async_count", 32'(bus.count), 32'd0);
    check("t5_async_wreq",  32'(bus.mem_wreq), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    #1;
    check("t5_post_wreq",  32'(bus.mem_wreq), 32'd0);
    check("t5_post_empty", 32'(bus.empty), 32'd1);
    bus.mem_wack = 1'b0;

`ifdef WBUF_COALESCE_EN
    // ---- coalescing into a non-head entry; head match allocates
    store(32'h60, 32'h1);
    tick();
    store(32'h64, 32'h2);
    tick();
    store(32'h64, 32'h9);
    #1 check("c_stall", 32'(bus.stall), 32'd0);
    tick();
    load(32'h64);
    #1;
    check("c_count", 32'(bus.count), 32'd2);
    check("c_fwd", bus.cpu_dout, 32'h9);
    store(32'h60, 32'h3);
    tick();
    idle();
    #1 check("c_head_alloc", 32'(bus.count), 32'd3);
    bus.mem_wack = 1'b1;
    check("c_a0", bus.mem_waddr, 32'h60);
    check("c_d0", bus.mem_wdata, 32'h1);
    tick();
    check("c_a1", bus.mem_waddr, 32'h64);
    check("c_d1", bus.mem_wdata, 32'h9);
    tick();
    check("c_a2", bus.mem_waddr, 32'h60);
    check("c_d2", bus.mem_wdata, 32'h3);
    tick();
    bus.mem_wack = 1'b0;
    #1 check("c_empty", 32'(bus.empty), 32'd1);
`else
    // ---- without coalescing, a repeated non-head address allocates
    store(32'h60, 32'h1);
    tick();
    store(32'h64, 32'h2);
    tick();
    store(32'h64, 32'h9);
    tick();
    idle();
    #1 check("nc_count", 32'(bus.count), 32'd3);
    bus.mem_wack = 1'b1;
    tick();
    check("nc_d1", bus.mem_wdata, 32'h2);
    tick();
    check("nc_d2", bus.mem_wdata, 32'h9);
    tick();
    bus.mem_wack = 1'b0;
    #1 check("nc_empty", 32'(bus.empty), 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
